// File: rtl/uart_rx_monitor.sv
// UART receive monitor: synchronizes a serial line, decodes 8N1 frames,
// and buffers received bytes in a small valid/ready FIFO.
//
// Output handshake: out_valid is high whenever the FIFO holds a byte and
// out_bits shows the head byte; a byte is consumed on every clock edge
// where out_valid && out_ready, and out_bits stays stable otherwise.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 174,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uart_txd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_bits,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          framing_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] HALF_M1 = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] BIT_M1  = 10'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Decoder state, kept as a named enum so checkers can bind to it.
  state_t      state;
  logic [1:0]  rst_pipe;
  logic        rst_int;
  logic [1:0]  sync_q;
  logic        rxs;
  logic        rxs_prev;
  logic [9:0]  cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        push;
  logic        pop;
  logic        full;
  logic        do_push;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Reset asserts immediately but releases only on a clock edge, two cycles later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];

  // Two-flop synchronizer on the serial line plus a delayed copy for edge detection.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      sync_q   <= 2'b11;
      rxs_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], uart_txd};
      rxs_prev <= rxs;
    end
  end

  assign rxs = sync_q[1];

  // Frame decoder: mid-bit sampling driven by a down-counter that reloads each bit.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rxs_prev && !rxs) begin
            state <= START;
            cnt   <= HALF_M1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rxs) begin
            state   <= DATA;
            cnt     <= BIT_M1;
            bit_idx <= '0;
          end else begin
            // Low pulse shorter than half a bit: treat as noise.
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= BIT_M1;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            framing_err <= 1'b1;
            state       <= BREAK;
          end
        end
        BREAK: begin
          // Wait out a held-low line; only a return to idle re-arms the decoder.
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push      = (state == STOP) && (cnt == '0) && rxs;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == FULL_COUNT);
  assign do_push   = push && (!full || pop);
  assign out_bits  = mem[rd_ptr];

  // Byte FIFO: a push into a full FIFO is accepted only when a pop frees a slot.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
